// File: rtl/sti_dac_gen.sv
// sti_dac_gen: serial-transmit / pixel-DAC engine.
// Accepts parallel words through a small command FIFO, serialises each word
// into a 1..4 half-word frame on so_data/so_valid, packs the transmitted bits
// into PIX_W-bit pixels for a 2^ADDR_W-entry pixel memory, pads the unused
// tail on end-of-stream and then raises a sticky pixel_finish.
// Ports:
//   clk, reset (async, active-low)
//   load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end : command push
//   pi_ready                                                  : push allowed
//   so_data, so_valid                                         : serial output
//   pixel_wr, pixel_addr, pixel_dataout                       : pixel memory write
//   pixel_finish                                              : stream complete
module sti_dac_gen #(
   parameter int unsigned       DATA_W     = 16,
   parameter int unsigned       PIX_W      = 8,
   parameter int unsigned       ADDR_W     = 8,
   parameter int unsigned       FIFO_DEPTH = 4,
   parameter logic [PIX_W-1:0]  PAD_VAL    = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] pi_data,
   input  logic [1:0]        pi_length,
   input  logic              pi_fill,
   input  logic              pi_msb,
   input  logic              pi_low,
   input  logic              pi_end,
   output logic              pi_ready,
   output logic              so_data,
   output logic              so_valid,
   output logic              pixel_wr,
   output logic [ADDR_W-1:0] pixel_addr,
   output logic [PIX_W-1:0]  pixel_dataout,
   output logic              pixel_finish
);

   localparam int unsigned H     = DATA_W / 2;
   localparam int unsigned FW    = 2 * DATA_W;
   localparam int unsigned CNT_W = $clog2(FW + 1);
   localparam int unsigned FA_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned FC_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PC_W  = (PIX_W > 1) ? $clog2(PIX_W) : 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [1:0]        len;
      logic              fill;
      logic              msb;
      logic              low;
      logic              last;
   } entry_t;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_FLUSH, S_DONE} state_t;

   state_t            state, state_d;
   entry_t            fifo_mem [FIFO_DEPTH];
   entry_t            head;
   logic [FA_W-1:0]   wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
   logic [FC_W-1:0]   count, count_d;
   logic [FW-1:0]     sh, sh_d, frame, aligned;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              cur_msb, cur_msb_d, cur_end, cur_end_d;
   logic [PIX_W-1:0]  acc, acc_d, dout_d;
   logic [PC_W-1:0]   pcnt, pcnt_d;
   logic [ADDR_W-1:0] addr_d;
   logic              so_data_d, so_valid_d, wr_d, finish_d, ready_d;
   logic              push, pop;
   int unsigned       l_bits;

   assign push = load && pi_ready;
   assign pop  = (state == S_FETCH);
   assign head = fifo_mem[rd_ptr];

   // Command storage; no reset needed, validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end};
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         sh            <= '0;
         cnt           <= '0;
         cur_msb       <= 1'b0;
         cur_end       <= 1'b0;
         acc           <= '0;
         pcnt          <= '0;
         so_data       <= 1'b0;
         so_valid      <= 1'b0;
         pixel_wr      <= 1'b0;
         pixel_addr    <= '0;
         pixel_dataout <= '0;
         pixel_finish  <= 1'b0;
         pi_ready      <= 1'b1;
      end else begin
         state         <= state_d;
         wr_ptr        <= wr_ptr_d;
         rd_ptr        <= rd_ptr_d;
         count         <= count_d;
         sh            <= sh_d;
         cnt           <= cnt_d;
         cur_msb       <= cur_msb_d;
         cur_end       <= cur_end_d;
         acc           <= acc_d;
         pcnt          <= pcnt_d;
         so_data       <= so_data_d;
         so_valid      <= so_valid_d;
         pixel_wr      <= wr_d;
         pixel_addr    <= addr_d;
         pixel_dataout <= dout_d;
         pixel_finish  <= finish_d;
         pi_ready      <= ready_d;
      end
   end

   // Next-state, FIFO bookkeeping, serialiser, pixel packer and flush.
   always_comb begin
      state_d    = state;
      count_d    = count + FC_W'(push) - FC_W'(pop);
      wr_ptr_d   = push ? wr_ptr + FA_W'(1) : wr_ptr;
      rd_ptr_d   = pop  ? rd_ptr + FA_W'(1) : rd_ptr;
      sh_d       = sh;
      cnt_d      = cnt;
      cur_msb_d  = cur_msb;
      cur_end_d  = cur_end;
      so_data_d  = 1'b0;
      so_valid_d = 1'b0;
      acc_d      = acc;
      pcnt_d     = pcnt;
      wr_d       = 1'b0;
      addr_d     = pixel_wr ? pixel_addr + ADDR_W'(1) : pixel_addr;
      dout_d     = pixel_dataout;
      finish_d   = pixel_finish;

      // Frame of the FIFO head, right-justified, then left-justified for MSB-first.
      l_bits = (32'(head.len) + 32'd1) * H;
      case (head.len)
         2'd0:    frame = head.low ? FW'(head.data[H-1:0]) : FW'(head.data[DATA_W-1:H]);
         2'd1:    frame = FW'(head.data);
         default: frame = head.fill ? (FW'(head.data) << (l_bits - DATA_W)) : FW'(head.data);
      endcase
      aligned = head.msb ? (frame << (FW - l_bits)) : frame;

      // Packer: first serial bit of a pixel lands in its MSB.
      if (so_valid) begin
         acc_d  = PIX_W'({acc, so_data});
         pcnt_d = pcnt + PC_W'(1);
         if (pcnt == PC_W'(PIX_W - 1)) begin
            wr_d   = 1'b1;
            dout_d = PIX_W'({acc, so_data});
            pcnt_d = '0;
         end
      end

      case (state)
         S_IDLE: begin
            if (count != '0 || push) state_d = S_FETCH;
         end
         S_FETCH: begin
            so_valid_d = 1'b1;
            so_data_d  = head.msb ? aligned[FW-1] : aligned[0];
            sh_d       = head.msb ? (aligned << 1) : (aligned >> 1);
            cnt_d      = CNT_W'(l_bits);
            cur_msb_d  = head.msb;
            cur_end_d  = head.last;
            state_d    = S_SHIFT;
         end
         S_SHIFT: begin
            if (cnt == CNT_W'(1)) begin
               if (cur_end)                   state_d = S_FLUSH;
               else if (count != '0 || push)  state_d = S_FETCH;
               else                           state_d = S_IDLE;
            end else begin
               so_valid_d = 1'b1;
               so_data_d  = cur_msb ? sh[FW-1] : sh[0];
               sh_d       = cur_msb ? (sh << 1) : (sh >> 1);
               cnt_d      = cnt - CNT_W'(1);
            end
         end
         S_FLUSH: begin
            // Entered with the last data pixel being written; pad writes
            // alternate with idle cycles until the top address is written.
            if (pixel_wr) begin
               if (pixel_addr == '1) begin
                  state_d  = S_DONE;
                  finish_d = 1'b1;
               end
            end else begin
               wr_d   = 1'b1;
               dout_d = PAD_VAL;
            end
         end
         S_DONE: begin
            finish_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (count_d < FC_W'(FIFO_DEPTH)) && (state_d != S_DONE);
   end

endmodule

// File: tb/tb_sti_dac_gen.sv
// Directed and randomized bench for sti_dac_gen with a bit-level reference
// model: expected serial bits are built from the frame rules with plain
// arithmetic, and expected pixel writes are the bit stream cut into bytes.
module tb_sti_dac_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] pi_data = '0;
   logic [1:0]  pi_length = '0;
   logic        pi_fill = 1'b0, pi_msb = 1'b0, pi_low = 1'b0, pi_end = 1'b0;
   logic        pi_ready, so_data, so_valid, pixel_wr, pixel_finish;
   logic [7:0]  pixel_addr, pixel_dataout;

   sti_dac_gen dut (
      .clk(clk), .reset(reset), .load(load), .pi_data(pi_data),
      .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
      .pi_low(pi_low), .pi_end(pi_end), .pi_ready(pi_ready),
      .so_data(so_data), .so_valid(so_valid), .pixel_wr(pixel_wr),
      .pixel_addr(pixel_addr), .pixel_dataout(pixel_dataout),
      .pixel_finish(pixel_finish)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_fail = 0;

   // Monitor state (written only by the monitor).
   int cyc = 0, run_len = 0, gap = 0, consec = 0, fin_cyc = -1;
   bit have_prev = 0, prev_wr = 0, prev_fin = 0;
   bit q_bits[$];
   int q_runs[$], q_gaps[$], q_pa[$], q_pd[$], q_wc[$];

   // Reference model state (written only by the stimulus block).
   bit exp_bits[$];
   int model_addr = 0;

   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         run_len = 0; have_prev = 0; prev_wr = 0; prev_fin = 0;
      end else begin
         if (so_valid) begin
            if (run_len == 0 && have_prev) q_gaps.push_back(gap);
            q_bits.push_back(so_data);
            run_len++;
         end else begin
            if (run_len > 0) begin
               q_runs.push_back(run_len); run_len = 0; have_prev = 1; gap = 0;
            end
            gap++;
         end
         if (pixel_wr) begin
            q_pa.push_back(int'(pixel_addr));
            q_pd.push_back(int'(pixel_dataout));
            q_wc.push_back(cyc);
            if (prev_wr) consec++;
         end
         prev_wr = pixel_wr;
         if (pixel_finish && !prev_fin) fin_cyc = cyc;
         prev_fin = pixel_finish;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Expected serial bits of one frame, straight from the length/fill/order rules.
   function automatic void add_frame(input logic [15:0] d, input logic [1:0] len,
                                     input logic fill, input logic msb, input logic low);
      int    L;
      longint v;
      L = (int'(len) + 1) * 8;
      if (len == 2'd0)      v = low ? longint'(d & 16'h00FF) : longint'(d >> 8);
      else if (len == 2'd1) v = longint'(d);
      else                  v = fill ? (longint'(d) << (L - 16)) : longint'(d);
      for (int i = 0; i < L; i++) exp_bits.push_back(v[msb ? (L - 1 - i) : i]);
   endfunction

   task automatic do_reset();
      reset = 1'b0; load = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      model_addr = 0;
      exp_bits.delete();
   endtask

   task automatic push(input logic [15:0] d, input logic [1:0] len, input logic f,
                       input logic m, input logic lo, input logic e);
      int   w;
      logic acc;
      w = 0;
      pi_data = d; pi_length = len; pi_fill = f; pi_msb = m; pi_low = lo; pi_end = e;
      load = 1'b1;
      do begin acc = pi_ready; tick(); w++; end while (!acc && w < 400);
      load = 1'b0;
      if (!acc) check("push accepted", 32'(acc), 32'd1);
      else add_frame(d, len, f, m, lo);
   endtask

   task automatic wait_idle();
      int w, quiet;
      w = 0; quiet = 0;
      while (quiet < 4 && w < 3000) begin
         tick(); w++;
         if (!so_valid && !pixel_wr) quiet++; else quiet = 0;
      end
      if (quiet < 4) check("idle timeout", 32'(w), 32'd0);
   endtask

   // Compare the observed bits/pixels since (b0,p0) with the model; flush adds pad writes.
   task automatic cmp_stream(input string tag, input int b0, input int p0, input bit flush);
      int mism, npix, npad, end_addr, aerr, derr, ea;
      logic [7:0] ed;
      check({tag, " bit count"}, 32'(q_bits.size() - b0), 32'(exp_bits.size()));
      mism = 0;
      for (int i = 0; i < exp_bits.size() && b0 + i < q_bits.size(); i++)
         if (q_bits[b0 + i] != exp_bits[i]) mism++;
      check({tag, " bit errors"}, 32'(mism), 32'd0);
      npix = exp_bits.size() / 8;
      end_addr = (model_addr + npix) % 256;
      npad = (flush && end_addr != 0) ? 256 - end_addr : 0;
      check({tag, " write count"}, 32'(q_pa.size() - p0), 32'(npix + npad));
      aerr = 0; derr = 0; ea = model_addr;
      for (int k = 0; k < npix + npad && p0 + k < q_pa.size(); k++) begin
         ed = 8'h00;
         if (k < npix) for (int j = 0; j < 8; j++) ed = {ed[6:0], exp_bits[8 * k + j]};
         if (q_pa[p0 + k] != ea) aerr++;
         if (q_pd[p0 + k] != int'(ed)) derr++;
         ea = (ea + 1) % 256;
      end
      check({tag, " addr errors"}, 32'(aerr), 32'd0);
      check({tag, " data errors"}, 32'(derr), 32'd0);
      model_addr = end_addr;
      exp_bits.delete();
   endtask

   function automatic int pd_at(input int i);
      return (i < q_pd.size()) ? q_pd[i] : -1;
   endfunction

   function automatic int pa_at(input int i);
      return (i < q_pa.size()) ? q_pa[i] : -1;
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   b0, p0, r0, n_acc, w, nb, errs, c0, wc_idx;
      logic acc, seen_low;
      int   e2[4];
      int   e3[3];

      // Reset values, checked while reset is asserted.
      #1 reset = 1'b0;
      #3;
      check("rst so_data", 32'(so_data), 32'd0);
      check("rst so_valid", 32'(so_valid), 32'd0);
      check("rst pixel_wr", 32'(pixel_wr), 32'd0);
      check("rst pixel_addr", 32'(pixel_addr), 32'd0);
      check("rst pixel_dataout", 32'(pixel_dataout), 32'd0);
      check("rst pixel_finish", 32'(pixel_finish), 32'd0);
      check("rst pi_ready", 32'(pi_ready), 32'd1);
      @(negedge clk); reset = 1'b1;
      tick();
      check("post-rst pi_ready", 32'(pi_ready), 32'd1);

      // 8-bit low half, MSB first, with load-to-output latency.
      b0 = q_bits.size(); p0 = q_pa.size();
      pi_data = 16'hA5C3; pi_length = 2'd0; pi_fill = 1'b0; pi_msb = 1'b1; pi_low = 1'b1; pi_end = 1'b0;
      load = 1'b1;
      tick();
      load = 1'b0;
      check("latency fetch cycle", 32'(so_valid), 32'd0);
      tick();
      check("latency first bit valid", 32'(so_valid), 32'd1);
      check("latency first bit", 32'(so_data), 32'd1);
      add_frame(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1);
      wait_idle();
      check("t1 pixel", 32'(pd_at(p0)), 32'hC3);
      check("t1 addr", 32'(pa_at(p0)), 32'd0);
      cmp_stream("t1", b0, p0, 1'b0);

      // 32-bit frame, data in MSBs, LSB first.
      do_reset();
      b0 = q_bits.size(); p0 = q_pa.size();
      push(16'h1234, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_idle();
      e2 = '{0, 0, 'h2C, 'h48};
      for (int k = 0; k < 4; k++) begin
         check("t2 pixel", 32'(pd_at(p0 + k)), 32'(e2[k]));
         check("t2 addr", 32'(pa_at(p0 + k)), 32'(k));
      end
      check("t2 frame length", 32'(q_runs[q_runs.size() - 1]), 32'd32);
      cmp_stream("t2", b0, p0, 1'b0);

      // 24-bit frame, zeros in MSBs, MSB first.
      do_reset();
      b0 = q_bits.size(); p0 = q_pa.size();
      push(16'hFFFF, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_idle();
      e3 = '{0, 'hFF, 'hFF};
      for (int k = 0; k < 3; k++) check("t3 pixel", 32'(pd_at(p0 + k)), 32'(e3[k]));
      cmp_stream("t3", b0, p0, 1'b0);

      // Load held for 8 cycles: back-pressure, drops, and 1-cycle frame gaps.
      b0 = q_bits.size(); p0 = q_pa.size(); r0 = q_runs.size();
      n_acc = 0; seen_low = 1'b0;
      pi_length = 2'd3; pi_fill = 1'($urandom); pi_msb = 1'($urandom); pi_end = 1'b0;
      for (int c = 0; c < 8; c++) begin
         pi_data = 16'($urandom);
         load = 1'b1;
         acc = pi_ready;
         if (!pi_ready) seen_low = 1'b1;
         if (acc) begin add_frame(pi_data, 2'd3, pi_fill, pi_msb, pi_low); n_acc++; end
         tick();
      end
      load = 1'b0;
      wait_idle();
      check("hold ready fell", 32'(seen_low), 32'd1);
      check("hold accepted", 32'(n_acc), 32'd5);
      check("hold frames", 32'(q_runs.size() - r0), 32'(n_acc));
      errs = 0;
      for (int i = r0; i < q_runs.size(); i++) if (q_runs[i] != 32) errs++;
      for (int i = q_gaps.size() - (n_acc - 1); i < q_gaps.size(); i++) if (q_gaps[i] != 1) errs++;
      check("hold length/gap errors", 32'(errs), 32'd0);
      cmp_stream("hold", b0, p0, 1'b0);

      // Randomized frames with random idle gaps between loads.
      b0 = q_bits.size(); p0 = q_pa.size();
      for (int i = 0; i < 30; i++) begin
         push(16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle();
      cmp_stream("random", b0, p0, 1'b0);

      // Reset during the 5th bit of a 16-bit frame.
      b0 = q_bits.size(); p0 = q_pa.size();
      push(16'($urandom), 2'd0, 1'b0, 1'b1, 1'($urandom), 1'b0);
      wait_idle();
      cmp_stream("pre-reset", b0, p0, 1'b0);
      check("pre-reset addr", 32'(pixel_addr), 32'(model_addr));
      push(16'($urandom), 2'd1, 1'b0, 1'($urandom), 1'b0, 1'b0);
      exp_bits.delete();
      nb = 0; w = 0;
      while (nb < 5 && w < 100) begin
         @(negedge clk); w++;
         if (so_valid) nb++;
      end
      check("midframe 5th bit reached", 32'(nb), 32'd5);
      reset = 1'b0;
      #1;
      check("midframe so_valid", 32'(so_valid), 32'd0);
      check("midframe pixel_addr", 32'(pixel_addr), 32'd0);
      check("midframe pixel_wr", 32'(pixel_wr), 32'd0);
      check("midframe pi_ready", 32'(pi_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      model_addr = 0;
      b0 = q_bits.size(); p0 = q_pa.size();
      push(16'($urandom), 2'd0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
      wait_idle();
      check("after-reset addr", 32'(pa_at(p0)), 32'd0);
      cmp_stream("after-reset", b0, p0, 1'b0);

      // End of stream: three 8-bit frames then padding to the top address.
      do_reset();
      b0 = q_bits.size(); p0 = q_pa.size(); c0 = consec;
      push(16'($urandom), 2'd0, 1'b0, 1'b1, 1'($urandom), 1'b0);
      push(16'($urandom), 2'd0, 1'b0, 1'b0, 1'($urandom), 1'b0);
      push(16'($urandom), 2'd0, 1'b0, 1'b1, 1'($urandom), 1'b1);
      w = 0;
      while (!pixel_finish && w < 3000) begin tick(); w++; end
      check("end finish", 32'(pixel_finish), 32'd1);
      tick();
      cmp_stream("end", b0, p0, 1'b1);
      check("end back-to-back writes", 32'(consec - c0), 32'd0);
      errs = 0;
      wc_idx = p0 + 2;
      for (int i = wc_idx + 1; i < q_wc.size(); i++) if (q_wc[i] - q_wc[i - 1] != 2) errs++;
      check("end write spacing", 32'(errs), 32'd0);
      check("end finish timing", 32'(fin_cyc - q_wc[q_wc.size() - 1]), 32'd1);
      check("end pi_ready", 32'(pi_ready), 32'd0);
      b0 = q_bits.size(); p0 = q_pa.size();
      pi_data = 16'hFFFF; pi_length = 2'd1; pi_end = 1'b0; load = 1'b1;
      repeat (3) tick();
      load = 1'b0;
      repeat (40) tick();
      check("done ignores load bits", 32'(q_bits.size() - b0), 32'd0);
      check("done ignores load writes", 32'(q_pa.size() - p0), 32'd0);
      check("done finish sticky", 32'(pixel_finish), 32'd1);

      // End frame's last pixel at the top address: no padding, done next cycle.
      do_reset();
      b0 = q_bits.size(); p0 = q_pa.size();
      for (int i = 0; i < 63; i++)
         push(16'($urandom), 2'd3, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         push(16'($urandom), 2'd0, 1'b0, 1'($urandom), 1'($urandom), 1'(i == 3));
      w = 0;
      while (!pixel_finish && w < 3000) begin tick(); w++; end
      check("top finish", 32'(pixel_finish), 32'd1);
      tick();
      check("top last addr", 32'(pa_at(q_pa.size() - 1)), 32'd255);
      check("top finish timing", 32'(fin_cyc - q_wc[q_wc.size() - 1]), 32'd1);
      cmp_stream("top", b0, p0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sti_dac_gen.md
# sti_dac_gen

Parametrised serial-transmit / pixel-DAC engine, successor to the fixed 16-bit STI_DAC. It accepts parallel words through a small command FIFO with ready back-pressure and serialises each word into a 1/2/3/4-half-word frame on so_data/so_valid. It also packs the transmitted bit stream into PIX_W-bit pixels written to a 2^ADDR_W-entry pixel memory, pads the unused tail on end-of-stream and then signals completion. It sits between the parallel pattern source and the pixel memory.

## Interface
- DATA_W, 16: parallel word width; even, ≥ 2·PIX_W; H = DATA_W/2 must be a multiple of PIX_W.
- PIX_W, 8: pixel width.
- ADDR_W, 8: pixel address width; memory has 2^ADDR_W entries.
- FIFO_DEPTH, 4: command FIFO entries; power of 2, ≥ 2.
- PAD_VAL, 0: PIX_W-bit value written to unused addresses at end-of-stream.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- load  in  1  push request; accepted when load && pi_ready.
- pi_data  in  DATA_W  parallel word.
- pi_length  in  2  frame length L = (pi_length+1)·H bits.
- pi_fill  in  1  padding side for L > DATA_W.
- pi_msb  in  1  1: frame MSB first; 0: LSB first.
- pi_low  in  1  L = H only: 1 selects the low half, 0 the high half.
- pi_end  in  1  sampled with load; marks the last word.
- pi_ready  out  1  FIFO not full and not finished.
- so_data  out  1  serial bit.
- so_valid  out  1  so_data valid.
- pixel_wr  out  1  one-cycle write strobe.
- pixel_addr  out  ADDR_W  write address.
- pixel_dataout  out  PIX_W  write data.
- pixel_finish  out  1  stream complete; sticky until reset.

## Operation
- Push: stores {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end} in the FIFO. A load while pi_ready=0 is dropped with no state change.
- Frame build, for L: pi_length=0 gives pi_data[H-1:0] if pi_low, else pi_data[DATA_W-1:H]. pi_length=1 gives pi_data.
- For pi_length 2/3, L−DATA_W zero bits are added. With pi_fill=1 the data occupies the MSBs and zeros the LSBs. With pi_fill=0 the zeros occupy the MSBs.
- Serialiser FSM:
  - IDLE → FETCH when the FIFO is non-empty.
  - FETCH pops one entry into the frame register and loads the bit counter with L.
  - FETCH → SHIFT.
  - SHIFT drives one bit per cycle for exactly L cycles, so_valid=1.
  - On the last bit: → FLUSH if the entry had end set; else → FETCH if the FIFO is non-empty; else → IDLE.
- Pixel packer:
  - Every bit with so_valid=1 shifts into the accumulator; the first bit becomes the pixel MSB.
  - Every PIX_W bits, pixel_wr pulses with the pixel and the current pixel_addr. pixel_addr then increments and wraps 2^ADDR_W−1 → 0, overwriting.
  - Frames are PIX_W-aligned, so no partial pixel exists between frames.
- FLUSH:
  - Writes PAD_VAL to every address from the current pixel_addr to 2^ADDR_W−1.
  - Each write is pixel_wr high 1 cycle, then low 1 cycle, so every write has a rising edge.
  - Then → DONE with pixel_finish=1.
  - If the end frame's last pixel lands at address 2^ADDR_W−1, FLUSH writes nothing and → DONE next cycle.
- DONE: pi_ready=0, loads ignored, outputs idle; left only by reset.

## Timing
- Reset values: pi_ready=1; so_data=0, so_valid=0, pixel_wr=0, pixel_addr=0, pixel_dataout=0, pixel_finish=0. FIFO empty, FSM IDLE.
- Latency: a load accepted at edge N gives FETCH in cycle N+1 and the first so_valid=1 in cycle N+2, when the serialiser is idle.
- Frame gap: exactly 1 cycle with so_valid=0 between consecutive frames (the FETCH cycle).
- pixel_wr: registered; high in the cycle after the PIX_W-th bit of the pixel is on so_data.
- pi_ready: derived from the registered FIFO count (count < FIFO_DEPTH) and not DONE. A simultaneous push and pop while full is not possible; when not full, both occur and the count is unchanged.
- Reset asserted mid-frame or mid-FLUSH:
  - All outputs go immediately to their reset values.
  - The FIFO and partial pixel are discarded.
  - The next stream starts at address 0.

## Test plan
- pi_data=0xA5C3, pi_length=0, pi_low=1, pi_msb=1 → so_data 1,1,0,0,0,0,1,1 over 8 valid cycles; pixel_wr at addr 0 with 0xC3.
- pi_data=0x1234, pi_length=3, pi_fill=1, pi_msb=0 → 32 valid cycles; pixels 0x00,0x00,0x2C,0x48 at addrs 0–3.
- pi_data=0xFFFF, pi_length=2, pi_fill=0, pi_msb=1 → 8 zeros then 16 ones; pixels 0x00,0xFF,0xFF.
- Hold load high for 8 cycles with pi_length=3 → pi_ready falls once 4 entries are queued. Dropped words are never transmitted. Frames seen equal accepted loads, each separated by one idle cycle.
- Three 8-bit frames, the last with pi_end=1 → pixels at addrs 0–2, then PAD_VAL written at addrs 3–255 with alternating pixel_wr, then pixel_finish=1 and held; a further load is ignored.
- Assert reset in the 5th bit of a 16-bit frame → so_valid=0 and pixel_addr=0 at once. After release, a new 8-bit frame writes its pixel at addr 0.
